piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter that feeds the 144-bit SIPO receiver over a one-wire data link plus a frame-start strobe.
- Accepts parallel words through a valid/ready handshake into a one-entry holding buffer.
- Serializes each word LSB-first, one bit per clock; each frame is preceded by a one-cycle start strobe wired to the receiver's valid_data input.
- Sits between the triangle-packing logic and the serial link; frames can run back-to-back.

Parameters:
WIDTH, 144, bits per frame; must be at least 2.
GAP_CYCLES, 0, extra idle cycles inserted after each frame's last bit before the next START.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
load_valid  input  1  load_data is valid this cycle.
load_data  input  WIDTH  word to transmit.
load_ready  output  1  holding buffer empty; the word is accepted on the edge where load_valid && load_ready.
ser_start  output  1  one-cycle frame-start strobe; connects to the receiver's valid_data.
ser_out  output  1  serial data bit.
ser_valid  output  1  high during the WIDTH data cycles of a frame.
piso_done  output  1  one-cycle pulse after a frame's last bit.
busy  output  1  state != IDLE.

Behaviour:
- Reset: state IDLE, buffer empty, shift register 0, count 0. While rst is high: load_ready=1, ser_start=0, ser_out=0, ser_valid=0, piso_done=0, busy=0.
- Holding buffer:
  - load_ready = !buf_full (combinational from the register).
  - On an accepted load: buf <= load_data, buf_full <= 1.
  - A load cannot be accepted while buf_full=1. load_data is ignored when load_ready=0.
- States: IDLE, START, SHIFT, GAP.
- IDLE: if buf_full, go to START on the next edge; otherwise stay.
- START (exactly 1 cycle):
  - ser_start=1, ser_valid=0, ser_out=0.
  - At the end of the cycle: sr <= buf, buf_full <= 0, count <= 0, go to SHIFT.
  - load_ready goes high in the first SHIFT cycle.
- SHIFT (exactly WIDTH cycles):
  - ser_valid=1, ser_out=sr[0].
  - Each edge: sr <= sr >> 1, count <= count + 1.
  - On the edge where count == WIDTH-1:
    - go to GAP if GAP_CYCLES > 0;
    - else go to START if buf_full (including a load accepted on that same edge);
    - else go to IDLE.
- Bit order: data cycle k (k = 0..WIDTH-1) carries load_data[k]. The SIPO then holds the word with bit 0 at out[0].
- piso_done: registered, high for exactly the one cycle after the last data cycle, whatever the next state is.
- GAP: count down GAP_CYCLES cycles with all link outputs 0, then go to START if buf_full, else IDLE.
- Link timing:
  - Last data bit in cycle k; earliest ser_start is cycle k+1; next first bit is cycle k+2.
  - This matches the receiver: it leaves its done/busy state on valid_data and shifts from the following cycle.
  - Back-to-back frame period is WIDTH+1+GAP_CYCLES cycles.
- Latency from an accepted load in IDLE (handshake edge at the end of cycle c):
  - buf_full=1 in cycle c+1; START in cycle c+2; first data bit in cycle c+3.
- Counter width is $clog2(WIDTH) bits and never exceeds WIDTH-1. The GAP counter is sized for GAP_CYCLES.
- Simultaneous events:
  - A load accepted in the same cycle as the last data bit is used by the immediately following START (no bubble when GAP_CYCLES=0).
  - A load presented during START while buf_full=1 is not accepted.
- Reset mid-frame: outputs drop immediately (asynchronous) and the buffered and shifting words are discarded. The receiver must share the same rst so both ends realign at frame 0.
- The first frame after reset is always preceded by START. A receiver that free-runs from reset is resynchronized by that strobe only after it has completed its first count; system bring-up keeps rst asserted until the first load.

Test Plan:
- Reset, then load 144'h1 (bit0=1) -> ser_start in cycle c+2. ser_out=1 in the first data cycle, 0 for the remaining 143. ser_valid high for exactly 144 cycles. piso_done pulses once, on the cycle after the last data bit.
- Loopback into the SIPO with pattern 144'hA5A5...A5 followed by 144'h0123456789ABCDEF0123456789ABCDEF0123 -> receiver out equals each word exactly; sipo_done pulses once per frame.
- Second load accepted while the first word is shifting (load_ready=1 during SHIFT) -> second ser_start in the cycle right after the last bit. Period is 145 cycles. load_ready=0 from the second accept until the next START completes.
- load_valid held high with 3 distinct words -> exactly 3 frames, no word dropped or duplicated. A load_data change while load_ready=0 has no effect.
- GAP_CYCLES=3 -> 3 idle cycles (all link outputs 0) between the last bit and the next ser_start. piso_done still pulses in the first idle cycle.
- Assert rst at data bit 70 of a frame with a word buffered -> all outputs 0 immediately. After release: IDLE, load_ready=1, no frame emitted until a new load.

Source files
------------

// File: rtl/piso_tx_if.sv
// Parallel load handshake and serial link signals between the packer, piso_tx and the SIPO side.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 144
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_start;
  logic             ser_out;
  logic             ser_valid;
  logic             piso_done;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, ser_start, ser_out, ser_valid, piso_done, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_start, ser_out, ser_valid, piso_done, busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one-entry holding buffer, START strobe, LSB-first frame,
// optional idle gap between frames.
module piso_tx #(
  parameter int unsigned WIDTH      = 144,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic       clk,
  input logic       rst,
  piso_tx_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StStart, StShift, StGap} state_e;

  state_e           r_state;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_sr;
  logic [CntW-1:0]  r_count;
  logic [GapW-1:0]  r_gap;
  logic             r_done;
  logic             w_accept;

  assign w_accept = bus.load_valid && !r_buf_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_sr       <= '0;
      r_count    <= '0;
      r_gap      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_buf      <= bus.load_data;
        r_buf_full <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (r_buf_full) r_state <= StStart;
        end
        // START is only entered with a full buffer, so no load can collide with the clear
        StStart: begin
          r_sr       <= r_buf;
          r_buf_full <= 1'b0;
          r_count    <= '0;
          r_state    <= StShift;
        end
        StShift: begin
          r_sr    <= r_sr >> 1;
          r_count <= r_count + CntW'(1);
          if (r_count == CntLast) begin
            r_done  <= 1'b1;
            r_count <= '0;
            if (GAP_CYCLES > 0) begin
              r_gap   <= GapLast;
              r_state <= StGap;
            end else if (r_buf_full || w_accept) begin
              r_state <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StGap: begin
          if (r_gap == '0) begin
            r_state <= r_buf_full ? StStart : StIdle;
          end else begin
            r_gap <= r_gap - GapW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Link outputs decode registered state only, so reset clears them asynchronously
  assign bus.load_ready = !r_buf_full;
  assign bus.ser_start  = (r_state == StStart);
  assign bus.ser_valid  = (r_state == StShift);
  assign bus.ser_out    = (r_state == StShift) && r_sr[0];
  assign bus.piso_done  = r_done;
  assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (no gap, 3-cycle gap) checked every cycle against a
// frame-schedule model, plus directed literal checks.
module tb_piso_tx;

  localparam int W = 144;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_tx_if #(.WIDTH(W)) if0 ();
  piso_tx_if #(.WIDTH(W)) if1 ();

  piso_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  piso_tx #(.WIDTH(W), .GAP_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic         lv [2];
  logic [W-1:0] ld [2];
  logic o_rdy [2], o_st [2], o_out [2], o_val [2], o_done [2], o_busy [2];

  assign if0.load_valid = lv[0];
  assign if0.load_data  = ld[0];
  assign if1.load_valid = lv[1];
  assign if1.load_data  = ld[1];
  assign o_rdy[0] = if0.load_ready;  assign o_rdy[1] = if1.load_ready;
  assign o_st[0]  = if0.ser_start;   assign o_st[1]  = if1.ser_start;
  assign o_out[0] = if0.ser_out;     assign o_out[1] = if1.ser_out;
  assign o_val[0] = if0.ser_valid;   assign o_val[1] = if1.ser_valid;
  assign o_done[0] = if0.piso_done;  assign o_done[1] = if1.piso_done;
  assign o_busy[0] = if0.busy;       assign o_busy[1] = if1.busy;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input int i, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  // Model: every accepted word becomes a frame scheduled by plain cycle arithmetic
  int           fstart [2][16];
  int           facc   [2][16];
  logic [W-1:0] fdata  [2][16];
  int           nf     [2] = '{0, 0};
  int           dstart [2][32];
  int           nds    [2] = '{0, 0};
  logic [W-1:0] rxw    [2];
  int           rxb    [2] = '{0, 0};
  int           rxn    [2] = '{0, 0};
  int           rxdone [2] = '{0, 0};

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_st, e_val, e_out, e_done, e_busy, e_rdy;
      int   t, s, l, g;
      t = cyc;
      g = gap_of(i);
      e_st = 1'b0; e_val = 1'b0; e_out = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
      if (rst) begin
        nf[i]  = 0;
        rxn[i] = 0;
        rxb[i] = 0;
      end else begin
        for (int f = 0; f < nf[i]; f++) begin
          s = fstart[i][f];
          l = s + W;
          if (t == s) e_st = 1'b1;
          if (t > s && t <= l) begin
            e_val = 1'b1;
            e_out = fdata[i][f][t - s - 1];
          end
          if (t == l + 1) e_done = 1'b1;
          if (t >= s && t <= l + g) e_busy = 1'b1;
          if (t > facc[i][f] && t <= s) e_rdy = 1'b0;
        end
      end
      check("ser_start", i, W'(o_st[i]), W'(e_st));
      check("ser_valid", i, W'(o_val[i]), W'(e_val));
      check("ser_out", i, W'(o_out[i]), W'(e_out));
      check("piso_done", i, W'(o_done[i]), W'(e_done));
      check("busy", i, W'(o_busy[i]), W'(e_busy));
      check("load_ready", i, W'(o_rdy[i]), W'(e_rdy));
      if (!rst) begin
        if (o_st[i] && nds[i] < 32) begin
          dstart[i][nds[i]] = t;
          nds[i]++;
        end
        // Receiver: rebuild each frame from the serial bits and compare to the loaded word
        if (o_st[i]) rxb[i] = 0;
        if (o_val[i] && rxb[i] < W) begin
          rxw[i][rxb[i]] = o_out[i];
          rxb[i]++;
          if (rxb[i] == W) begin
            check("loopback_word", i, rxw[i], (rxn[i] < nf[i]) ? fdata[i][rxn[i]] : ~rxw[i]);
            rxn[i]++;
            rxdone[i]++;
            rxb[i] = 0;
          end
        end
        if (lv[i] && e_rdy) begin
          if (nf[i] == 0) begin
            s = t + 2;
          end else begin
            l = fstart[i][nf[i] - 1] + W;
            if (g == 0 && t <= l) s = l + 1;
            else s = (t + 2 > l + 1 + g) ? t + 2 : l + 1 + g;
          end
          if (nf[i] < 16) begin
            fstart[i][nf[i]] = s;
            facc[i][nf[i]]   = t;
            fdata[i][nf[i]]  = ld[i];
            nf[i]++;
          end else begin
            check("model_capacity", i, W'(nf[i]), W'(15));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [W-1:0] d);
    lv[0] = 1'b1; lv[1] = 1'b1;
    ld[0] = d;    ld[1] = d;
  endtask

  task automatic idle_both();
    lv[0] = 1'b0; lv[1] = 1'b0;
  endtask

  function automatic logic [W-1:0] junk();
    logic [159:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return v[W-1:0];
  endfunction

  initial begin
    int c0, vcnt, ocnt, dcnt, done_at, scnt;
    int widx [2];
    logic hs [2];
    logic [W-1:0] words [3];
    words[0] = {9{16'hC3E1}};
    words[1] = {18{8'h5A}} ^ {W{1'b1}};
    words[2] = {36{4'h9}};
    idle_both();
    ld[0] = '0; ld[1] = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Single bit-0 word: latency, bit order, frame length, done pulse
    c0 = cyc;
    load_both(W'(1));
    step();
    idle_both();
    check("t1_ready_after_accept", 0, W'(o_rdy[0]), W'(0));
    check("t1_no_start_c1", 0, W'(o_st[0]), W'(0));
    step();
    check("t1_start_c2", 0, W'(o_st[0]), W'(1));
    check("t1_start_c2", 1, W'(o_st[1]), W'(1));
    vcnt = 0; ocnt = 0; dcnt = 0; done_at = 0;
    for (int k = 3; k <= 150; k++) begin
      step();
      if (k == 3) check("t1_first_bit", 0, W'(o_out[0]), W'(1));
      if (o_val[0]) vcnt++;
      if (o_val[0] && o_out[0]) ocnt++;
      if (o_done[0]) begin
        dcnt++;
        done_at = k;
      end
    end
    check("t1_valid_cycles", 0, W'(vcnt), W'(144));
    check("t1_one_bits", 0, W'(ocnt), W'(1));
    check("t1_done_pulses", 0, W'(dcnt), W'(1));
    check("t1_done_offset", 0, W'(done_at), W'(147));
    check("t1_start_latency", 0, W'(dstart[0][0] - c0), W'(2));

    // Two words, second loaded mid-shift: back-to-back frames
    repeat (5) step();
    load_both({18{8'hA5}});
    step();
    idle_both();
    repeat (19) step();
    load_both(144'h0123456789ABCDEF0123456789ABCDEF0123);
    step();
    idle_both();
    check("t2_ready_low_after_accept", 0, W'(o_rdy[0]), W'(0));
    repeat (360) step();
    check("t2_period_nogap", 0, W'(dstart[0][2] - dstart[0][1]), W'(145));
    check("t2_period_gap3", 1, W'(dstart[1][2] - dstart[1][1]), W'(148));

    // load_valid held high, garbage data whenever the buffer is full
    widx[0] = 0; widx[1] = 0;
    for (int k = 0; k < 700 && (widx[0] < 3 || widx[1] < 3); k++) begin
      for (int i = 0; i < 2; i++) begin
        lv[i] = (widx[i] < 3);
        ld[i] = (o_rdy[i] && widx[i] < 3) ? words[widx[i]] : junk();
        hs[i] = lv[i] && o_rdy[i];
      end
      step();
      for (int i = 0; i < 2; i++) if (hs[i]) widx[i]++;
    end
    idle_both();
    check("t3_words_taken", 0, W'(widx[0]), W'(3));
    check("t3_words_taken", 1, W'(widx[1]), W'(3));
    repeat (400) step();
    check("t3_frames_total", 0, W'(rxdone[0]), W'(6));
    check("t3_frames_total", 1, W'(rxdone[1]), W'(6));

    // Reset at data bit 70 with a second word buffered
    load_both({4{36'h123456789}});
    step();
    idle_both();
    repeat (9) step();
    load_both({W{1'b1}});
    step();
    idle_both();
    repeat (62) step();
    check("t4_shifting_before_rst", 0, W'(o_val[0]), W'(1));
    check("t4_buffer_full_before_rst", 0, W'(o_rdy[0]), W'(0));
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t4_rst_start", i, W'(o_st[i]), W'(0));
      check("t4_rst_valid", i, W'(o_val[i]), W'(0));
      check("t4_rst_busy", i, W'(o_busy[i]), W'(0));
      check("t4_rst_ready", i, W'(o_rdy[i]), W'(1));
    end
    step();
    step();
    rst = 1'b0;
    scnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_st[0] || o_st[1] || o_val[0] || o_val[1]) scnt++;
    end
    check("t4_no_frame_after_rst", 0, W'(scnt), W'(0));
    check("t4_ready_after_rst", 0, W'(o_rdy[0]), W'(1));
    check("t4_total_starts", 0, W'(nds[0]), W'(7));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
